// File: rtl/oddr_pkg.sv
// Shared definitions for the DDR transmit path: FSM state encoding and a
// constant-width helper used to size the pair counter.
package oddr_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/oddr_cell.sv
// DDR output cell: posedge-captured rise/fall bits, fall bit re-timed on the
// negedge, and a clock-selected mux so the pin only changes at clock edges.
module oddr_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic d_r,
    input  logic d_f,
    input  logic en,
    input  logic idle_val,
    output logic q
);

    logic r_d, f_d;
    logic r_q, f_q, fn_q;

    assign r_d = en ? d_r : idle_val;
    assign f_d = en ? d_f : idle_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= idle_val;
            f_q <= idle_val;
        end else begin
            r_q <= r_d;
            f_q <= f_d;
        end
    end

    // Holding the fall bit until the negedge keeps it off the pin during the high phase.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) fn_q <= idle_val;
        else        fn_q <= f_q;
    end

    assign q = clk ? r_q : fn_q;

endmodule

// File: rtl/oddr_ctrl.sv
// DDR transmit controller: valid/ready word input, MSB-first serialization at
// two bits per clock. Optional forwarded clock output under ODDR_CTRL_FWD_CLK_EN.
module oddr_ctrl
    import oddr_pkg::*;
#(
    parameter int   DATA_W   = 8,
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              din_vld,
    output logic              din_rdy,
    output logic              dout,
    output logic              dout_en,
    output logic              busy
`ifdef ODDR_CTRL_FWD_CLK_EN
   ,output logic              clk_fwd
`endif
);

    localparam int PAIRS = DATA_W / 2;
    localparam int CNT_W = (clog2(PAIRS) < 1) ? 1 : clog2(PAIRS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PAIRS - 1);

    state_e              state_q, state_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                rdy_en_q;
    logic                dout_en_q;
    logic                hs;

    assign hs = din_vld & din_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // A handshake on the last pair reloads instead of returning to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (hs) state_d = ST_SHIFT;
            ST_SHIFT: if ((cnt_q == '0) && !hs) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        busy    = (state_q == ST_SHIFT);
        din_rdy = rdy_en_q & ((state_q == ST_IDLE) | ((state_q == ST_SHIFT) & (cnt_q == '0)));
    end

    always_comb begin
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        if (hs) begin
            shreg_d = din;
            cnt_d   = CNT_LAST;
        end else if (state_q == ST_SHIFT) begin
            shreg_d = shreg_q << 2;
            if (cnt_q != '0) cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shreg_q   <= '0;
            cnt_q     <= '0;
            rdy_en_q  <= 1'b0;
            dout_en_q <= 1'b0;
        end else begin
            shreg_q   <= shreg_d;
            cnt_q     <= cnt_d;
            rdy_en_q  <= 1'b1;
            dout_en_q <= busy;
        end
    end

    assign dout_en = dout_en_q;

    oddr_cell u_data_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_r      (shreg_q[DATA_W-1]),
        .d_f      (shreg_q[DATA_W-2]),
        .en       (busy),
        .idle_val (IDLE_VAL),
        .q        (dout)
    );

`ifdef ODDR_CTRL_FWD_CLK_EN
    // Same enable as the data cell, so the forwarded clock is edge-aligned with dout.
    oddr_cell u_clk_cell (
        .clk      (clk),
        .rst_n    (rst_n),
        .d_r      (1'b1),
        .d_f      (1'b0),
        .en       (busy),
        .idle_val (1'b0),
        .q        (clk_fwd)
    );
`endif

endmodule

// File: doc/oddr_ctrl.md
# oddr_ctrl

Transmit-side DDR output controller: the counterpart of the IDDR capture path. It accepts parallel words over a valid/ready handshake, serializes them MSB-first at two bits per clock, and drives one double-data-rate output pin: one bit in the clock-high half, one in the clock-low half. It sits between on-chip logic and the pad. The frame qualifier `dout_en` is driven so a receiving `iddr_ctrl` can gate capture with its `clk_en`.

## Interface
- `DATA_W`, 8: word width; must be even and ≥2.
- `IDLE_VAL`, 1'b0: level driven on `dout` in both half-cycles when no word is being sent.
- `clk` input 1: single system clock; both edges are used by the output cell.
- `rst_n` input 1: asynchronous, active-low reset.
- `din` input DATA_W: word to transmit.
- `din_vld` input 1: `din` valid.
- `din_rdy` output 1: ready; a transfer occurs on a posedge with `din_vld & din_rdy`.
- `dout` output 1: DDR serial data.
- `dout_en` output 1: SDR frame qualifier; high for every clock cycle that carries word bits.
- `busy` output 1: high while a word is loaded and not yet fully emitted.

## Operation
- FSM states:
  - IDLE: no word loaded.
  - SHIFT: word loaded; pair counter `cnt` runs from DATA_W/2-1 down to 0.
- `din_rdy` = `rdy_en` & (IDLE | (SHIFT & cnt==0)).
  - `rdy_en` is a flop cleared by reset and set on the first posedge after `rst_n` rises.
- Handshake at a posedge: `shreg` ← `din`, `cnt` ← DATA_W/2-1, state ← SHIFT.
- Each posedge in SHIFT:
  - Output cell captures `d_r` ← `shreg[W-1]` and `d_f` ← `shreg[W-2]`.
  - `dout_en` ← 1.
  - `shreg` ← `shreg`<<2 and `cnt` ← `cnt`-1.
  - If `cnt` reaches 0 with no handshake, the next state is IDLE.
- Each posedge in IDLE: `d_r` ← `d_f` ← IDLE_VAL, `dout_en` ← 0.
- Simultaneous last-pair emit and new handshake (cnt==0): the last pair is emitted and the new word is loaded in the same edge. Frames are then gapless and `dout_en` stays high.
- `busy` = (state==SHIFT).
- Bit order: `din[W-1]` goes out first (rising half), `din[W-2]` second (falling half), down to `din[0]`.
- Reset mid-word: everything clears asynchronously and the word is discarded. There is no partial resend.

## Timing
- Reset values:
  - `dout` = IDLE_VAL, `dout_en` = 0, `din_rdy` = 0, `busy` = 0.
  - State IDLE, `shreg` = 0, `cnt` = 0.
- Latency: word accepted at posedge k → `dout` carries `din[W-1]` during the high phase after posedge k+1 and `din[W-2]` during the following low phase.
- A word occupies DATA_W/2 consecutive cycles (k+1 … k+DATA_W/2). `dout_en` is high over exactly those cycles.
- Output cell:
  - `d_r` and `d_f` are registered on posedge.
  - `d_f` is re-registered on negedge into `d_fn`.
  - `dout` = clk ? `d_r` : `d_fn`. The mux select is the clock only, so `dout` is glitch-free.
- Maximum throughput: one word per DATA_W/2 cycles.

## Configuration
- `ODDR_CTRL_FWD_CLK_EN`:
  - Defined: adds output `clk_fwd`, produced by a second `oddr_cell` with `d_r`=1 and `d_f`=0 while `dout_en`, and 0/0 otherwise. `clk_fwd` is edge-aligned with `dout` and toggles only during frames. Its reset value is 0.
  - Undefined: the port and the cell are absent.

## Structure
- Shared package `oddr_pkg`: FSM state encoding (IDLE, SHIFT) and the `clog2` helper used to size `cnt`.
- Sub-module `oddr_cell`:
  - Ports: `clk`, `rst_n`, `d_r`, `d_f`, `en`, `idle_val`, `q`.
  - Holds the posedge/negedge registers and the clock-select mux.
  - Instantiated once for `dout`, and once more for `clk_fwd` under the macro.

## Test plan
- Single word, DATA_W=8, `din`=8'hA5 accepted at posedge k → `dout` half-cycle sequence 1,0,1,0,0,1,0,1 over cycles k+1..k+4. `dout_en` is high for exactly those 4 cycles, then `dout`=IDLE_VAL.
- Back-to-back: 8'hFF then 8'h00 with `din_vld` held high → second accepted at the cnt==0 edge. `dout` is 8 half-cycles of 1 then 8 of 0. `dout_en` stays high for 8 cycles with no gap.
- Backpressure: `din_vld` raised with 8'h3C one cycle after a word starts → `din_rdy` stays low until cnt==0 and `din` is held. 8'h3C follows with no gap and no duplication.
- Reset mid-word: drop `rst_n` during cycle k+2 of 8'hA5 → `dout`=IDLE_VAL, `dout_en`=0, `din_rdy`=0 immediately. After release, `din_rdy` rises 1 cycle later and no leftover bits are emitted.
- Loopback: connect `dout` and `dout_en` to `iddr_ctrl` (`din`, `clk_en`) and send 100 random words → recovered (`dout1`,`dout2`) pairs match the transmitted bit pairs.
- With `ODDR_CTRL_FWD_CLK_EN`: `clk_fwd` toggles in phase with `clk` only while `dout_en`=1 and holds 0 in idle and reset.
